// File: rtl/gray_counter_enc_if.sv
// Control/status bundle for the up/down binary+Gray counter.
// Master drives count controls; slave returns the registered codes.
interface gray_counter_enc_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             err;

  modport master (
    output en, up_dn, load, load_bin,
    input  bin, gray, wrap, err
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output bin, gray, wrap, err
  );
endinterface

// File: rtl/gray_counter_enc.sv
// Up/down binary counter with registered Gray code and wrap pulse.
// Define GRAY_ADJ_CHECK_EN to build the sticky Gray-adjacency checker.
module gray_counter_enc #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  gray_counter_enc_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gray_counter_enc: WIDTH out of range");
  end

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] g_next;
  logic             wrap_q;
  logic             wrap_next;
  logic             cnt;

  assign cnt = bus.en & ~bus.load;

  always_comb begin
    b_next    = b_q;
    wrap_next = 1'b0;
    unique case (1'b1)
      bus.load: begin
        b_next = bus.load_bin;
      end
      cnt & bus.up_dn: begin
        b_next    = b_q + ONE;
        wrap_next = (b_q == ONES);
      end
      cnt & ~bus.up_dn: begin
        b_next    = b_q - ONE;
        wrap_next = (b_q == '0);
      end
      default: begin
        b_next    = b_q;
        wrap_next = 1'b0;
      end
    endcase
  end

  // Gray is encoded from the next binary value so both land together.
  assign g_next = b_next ^ (b_next >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_next;
      g_q    <= g_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.bin  = b_q;
  assign bus.gray = g_q;
  assign bus.wrap = wrap_q;

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             adj_ok;
  logic             first_q;
  logic             err_q;

  // Exactly one bit set: nonzero and clearing the lowest set bit gives 0.
  assign diff   = g_q ^ g_next;
  assign adj_ok = (diff != '0) && ((diff & (diff - ONE)) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (cnt && !first_q && !adj_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_enc.sv
// Directed table-driven bench for gray_counter_enc at WIDTH=4.
// Adjacency-checker sequence builds only with GRAY_ADJ_CHECK_EN.
module tb_gray_counter_enc;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  gray_counter_enc_if #(.WIDTH(4)) bus ();

  gray_counter_enc #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       load;
    logic       en;
    logic       up_dn;
    logic [3:0] lb;
    logic [3:0] eb;
    logic [3:0] eg;
    logic       ew;
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic l, input logic e,
                      input logic u, input logic [3:0] lb);
    bus.load     = l;
    bus.en       = e;
    bus.up_dn    = u;
    bus.load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eb,
                           input logic [3:0] eg, input logic ew);
    check({tag, "_bin"},  16'(bus.bin),  16'(eb));
    check({tag, "_gray"}, 16'(bus.gray), 16'(eg));
    check({tag, "_wrap"}, 16'(bus.wrap), 16'(ew));
  endtask

  logic [3:0] mb;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.load = 1'b0;
    bus.en = 1'b0;
    bus.up_dn = 1'b1;
    bus.load_bin = 4'h0;

    //            load en up  lb     bin    gray   wrap
    vt[0]  = '{1'b1, 1'b1, 1'b1, 4'hC, 4'hC, 4'hA, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 4'h8, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 4'h6, 4'h6, 4'h5, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 4'h9, 4'h6, 4'h5, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h6, 4'h5, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 4'hF, 4'h6, 4'h5, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0};

    // Asynchronous reset: outputs clear with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_async", 4'h0, 4'h0, 1'b0);
    check("rst_err", 16'(bus.err), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Count to 3, then reset mid-count.
    step(1'b0, 1'b1, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0);
    check_all("pre_rst", 4'h3, 4'h2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 4'h0);
    check_all("post_rst1", 4'h1, 4'h1, 1'b0);
    check("post_rst_err", 16'(bus.err), 16'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'h0);
    check_all("five_up", 4'h5, 4'h7, 1'b0);
    check("five_up_err", 16'(bus.err), 16'h0);

    // No combinational path from inputs to outputs.
    bus.load = 1'b1;
    bus.load_bin = 4'hA;
    #2;
    check("no_comb_bin", 16'(bus.bin), 16'h5);
    bus.load = 1'b0;
    #2;

    for (int i = 0; i < 15; i++) begin
      step(vt[i].load, vt[i].en, vt[i].up_dn, vt[i].lb);
      check_all($sformatf("vec%0d", i), vt[i].eb, vt[i].eg, vt[i].ew);
    end

    // Full up sweep then full down sweep against a reference model.
    step(1'b1, 1'b0, 1'b1, 4'h0);
    mb = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'h0);
      mb = mb + 4'h1;
      check_all($sformatf("up%0d", i), mb, mb ^ (mb >> 1), mb == 4'h0);
      check($sformatf("up%0d_err", i), 16'(bus.err), 16'h0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0);
      mb = mb - 4'h1;
      check_all($sformatf("dn%0d", i), mb, mb ^ (mb >> 1), mb == 4'hF);
      check($sformatf("dn%0d_err", i), 16'(bus.err), 16'h0);
    end

`ifdef GRAY_ADJ_CHECK_EN
    // Corrupt the gray register so the next count jumps by several bits.
    step(1'b1, 1'b0, 1'b1, 4'h0);
    force dut.g_q = 4'b0110;
    step(1'b0, 1'b1, 1'b1, 4'h0);
    release dut.g_q;
    check("adj_err_set", 16'(bus.err), 16'h1);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0);
    check("adj_err_sticky", 16'(bus.err), 16'h1);
    step(1'b1, 1'b0, 1'b1, 4'h3);
    check("adj_err_sticky_ld", 16'(bus.err), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check("adj_err_rst", 16'(bus.err), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 4'h0);
    check("adj_err_clear", 16'(bus.err), 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter_enc.md
GRAY_COUNTER_ENC -- requirements
Module: gray_counter_enc

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the counter and code width in bits; legal range is 2 to 16.
REQ-002 SHALL provide port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port en  input  1  count enable.
REQ-005 SHALL provide port up_dn  input  1  count direction: 1 = up, 0 = down.
REQ-006 SHALL provide port load  input  1  synchronous load strobe.
REQ-007 SHALL provide port load_bin  input  WIDTH  binary value to load.
REQ-008 SHALL provide port bin  output  WIDTH  registered binary count.
REQ-009 SHALL provide port gray  output  WIDTH  registered Gray encoding of bin.
REQ-010 SHALL provide port wrap  output  1  one-cycle pulse on count wrap-around.
REQ-011 SHALL provide port err  output  1  sticky Gray-adjacency error flag (see Configuration).

Function
REQ-012 SHALL hold internal binary state B; on each clk edge, next B is: load_bin if load=1; else B+1 mod 2^WIDTH if en=1 and up_dn=1; else B-1 mod 2^WIDTH if en=1 and up_dn=0; else B.
REQ-013 SHALL give load priority over en; load with en=1 loads only, no count that cycle.
REQ-014 SHALL register gray in the same edge as bin, from next B: gray = nextB XOR (nextB >> 1); gray SHALL always equal the encoding of the current bin, with zero relative latency.
REQ-015 SHALL update bin and gray one clk edge after the controlling inputs are sampled; there is no combinational path from inputs to outputs.
REQ-016 SHALL assert wrap for exactly one cycle after an edge where a count moves B from all-ones to 0 (up) or from 0 to all-ones (down); otherwise wrap=0.
REQ-017 SHALL NOT assert wrap on a load, including a load of 0 or all-ones.
REQ-018 SHALL hold bin, gray, and wrap=0 while en=0 and load=0.
REQ-019 SHALL accept an up_dn change on any cycle; the count moves in the new direction on that same edge.

Reset
REQ-020 SHALL, while rst=1, force bin=0, gray=0, wrap=0, and err=0 immediately, independent of clk.
REQ-021 SHALL, when rst deasserts mid-count, resume from 0 on the first clk edge with rst=0; the reset-to-0 transition SHALL NOT generate a wrap pulse or an err.

Configuration
REQ-022 SHALL, when macro GRAY_ADJ_CHECK_EN is defined, compare each new gray value with the previous one on every counting edge (en=1, load=0, not the first edge after reset), and set err=1 if the values differ in other than exactly one bit; err SHALL stay set until rst.
REQ-023 SHALL exclude load edges and hold edges from the adjacency check.
REQ-024 SHALL, when GRAY_ADJ_CHECK_EN is not defined, keep the err port and tie it to constant 0, with no checker logic synthesized.

Verification (WIDTH=4)
REQ-025 SHALL cover: rst pulse mid-count, then 5 cycles with en=1 and up_dn=1 -> bin=0101, gray=0111, wrap=0, err=0.
REQ-026 SHALL cover: load=1, en=1, load_bin=1100 -> next cycle bin=1100, gray=1010, no count applied.
REQ-027 SHALL cover: load 1111, then one up count -> bin=0000, gray=0000, wrap=1 for exactly one cycle.
REQ-028 SHALL cover: from bin=0000, one down count -> bin=1111, gray=1000, wrap=1 for one cycle; the next down count gives bin=1110, gray=1001, wrap=0.
REQ-029 SHALL cover: en=0 and load=0 for 4 cycles at bin=0110 -> bin=0110 and gray=0101 held, wrap=0.
REQ-030 SHALL cover, with GRAY_ADJ_CHECK_EN: a full 16-count up sweep plus a 16-count down sweep -> err stays 0; forcing the gray register through a 2-bit jump sets err=1 until rst.
